// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two 64-bit masters shared access to a 32-bit BRAM window.
module mem_arbiter #(
  parameter logic [63:0] BASE  = 64'h0,
  parameter int          WORDS = 3072,
  parameter int          AW    = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [63:0]   m0_addr,
  input  logic [63:0]   m0_wdata,
  output logic [63:0]   m0_rdata,
  output logic          m0_done,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [63:0]   m1_addr,
  input  logic [63:0]   m1_wdata,
  output logic [63:0]   m1_rdata,
  output logic          m1_done,
  output logic [AW-1:0] mem_addr,
  output logic          mem_en,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          grant
);
  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, DONE} state_t;
  localparam logic [63:0] LIMIT = BASE + 64'(WORDS) * 64'd4;
  state_t r_state;
  logic r_we, r_in;
  logic w_pick, w_we, w_in, w_unused;
  logic [63:0] w_addr, w_wdata, w_off;
  // Contention goes to the master that did not own the last transaction.
  always_comb begin
    w_pick   = (m0_req && m1_req) ? ~grant : m1_req;
    w_we     = w_pick ? m1_we : m0_we;
    w_addr   = w_pick ? m1_addr : m0_addr;
    w_wdata  = w_pick ? m1_wdata : m0_wdata;
    w_off    = w_addr - BASE;
    w_in     = (w_addr >= BASE) && (w_addr < LIMIT);
    w_unused = ^{w_wdata[63:32], w_off[63:AW+2], w_off[1:0]};
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_in      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      m0_done   <= 1'b0;
      m1_done   <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
      grant     <= 1'b1;
    end else begin
      case (r_state)
        IDLE: if (m0_req || m1_req) begin
          grant     <= w_pick;
          r_we      <= w_we;
          r_in      <= w_in;
          mem_addr  <= w_off[AW+1:2];
          mem_wdata <= w_wdata[31:0];
          mem_en    <= w_in;
          mem_we    <= w_in && w_we;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          mem_en <= 1'b0;
          mem_we <= 1'b0;
          if (r_in && !r_we) r_state <= RWAIT;
          else begin
            r_state <= DONE;
            m0_done <= !grant;
            m1_done <= grant;
            if (!r_we && !grant) m0_rdata <= '0;
            if (!r_we && grant) m1_rdata <= '0;
          end
        end
        RWAIT: begin
          r_state <= DONE;
          m0_done <= !grant;
          m1_done <= grant;
          if (!grant) m0_rdata <= {32'h0, mem_rdata};
          if (grant) m1_rdata <= {32'h0, mem_rdata};
        end
        DONE: begin
          m0_done <= 1'b0;
          m1_done <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end
endmodule
